// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with block refill
module icache #(
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH,
  parameter int BLOCK_WIDTH  = 128
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic                   if2cache_en,
  input  logic [31:0]            if2cache_pc,
  output logic                   cache2if_rdy,
  output logic [31:0]            cache2if_inst,
  output logic                   cache2mem_upd_en,
  output logic [31:0]            cache2mem_PC,
  input  logic                   mem2cache_upd,
  input  logic [BLOCK_WIDTH-1:0] mem2cache_blk,
  input  logic [INDEX_WIDTH-1:0] mem2cache_idx,
  input  logic [TAG_WIDTH-1:0]   mem2cache_tag
);

  localparam int LINES  = 1 << INDEX_WIDTH;
  localparam int WSEL_W = OFFSET_WIDTH - 2;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t                 r_state;
  logic [LINES-1:0]       r_valid;
  logic [TAG_WIDTH-1:0]   r_tag  [LINES];
  logic [BLOCK_WIDTH-1:0] r_data [LINES];
  logic [31:2]            r_pc;
  logic                   r_drop;
  logic                   r_rdy;
  logic [31:0]            r_inst;
  logic                   r_upd_en;
  logic [31:0]            r_mem_pc;

  logic [TAG_WIDTH-1:0]   w_req_tag;
  logic [INDEX_WIDTH-1:0] w_req_idx;
  logic [WSEL_W-1:0]      w_req_wsel;
  logic                   w_hit;
  logic [31:0]            w_hit_word;
  logic [TAG_WIDTH-1:0]   w_lat_tag;
  logic [INDEX_WIDTH-1:0] w_lat_idx;
  logic [WSEL_W-1:0]      w_lat_wsel;
  logic                   w_fill_match;
  logic [31:0]            w_fill_word;
  logic                   w_unused;

  assign w_req_tag  = if2cache_pc[31 -: TAG_WIDTH];
  assign w_req_idx  = if2cache_pc[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_req_wsel = if2cache_pc[2 +: WSEL_W];
  assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_hit_word = r_data[w_req_idx][{w_req_wsel, 5'b0} +: 32];
  assign w_unused   = ^if2cache_pc[1:0];

  // The fill is compared against the latched miss address, and the
  // response word is forwarded straight from the incoming block.
  assign w_lat_tag    = r_pc[31 -: TAG_WIDTH];
  assign w_lat_idx    = r_pc[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_lat_wsel   = r_pc[2 +: WSEL_W];
  assign w_fill_match = (mem2cache_idx == w_lat_idx) && (mem2cache_tag == w_lat_tag);
  assign w_fill_word  = mem2cache_blk[{w_lat_wsel, 5'b0} +: 32];

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_pc     <= '0;
      r_drop   <= 1'b0;
      r_rdy    <= 1'b0;
      r_inst   <= '0;
      r_upd_en <= 1'b0;
      r_mem_pc <= '0;
    end else if (rdy_in) begin
      case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b0;
          if (if2cache_en && !flush_in) begin
            r_pc <= if2cache_pc[31:2];
            if (w_hit) begin
              r_rdy  <= 1'b1;
              r_inst <= w_hit_word;
            end else begin
              r_state  <= S_MISS;
              r_upd_en <= 1'b1;
              r_mem_pc <= {w_req_tag, w_req_idx, {OFFSET_WIDTH{1'b0}}};
            end
          end
        end
        S_MISS: begin
          r_rdy <= 1'b0;
          if (flush_in) r_drop <= 1'b1;
          if (mem2cache_upd) begin
            r_data[mem2cache_idx]  <= mem2cache_blk;
            r_tag[mem2cache_idx]   <= mem2cache_tag;
            r_valid[mem2cache_idx] <= 1'b1;
            if (w_fill_match) begin
              r_state  <= S_IDLE;
              r_upd_en <= 1'b0;
              r_drop   <= 1'b0;
              if (!r_drop && !flush_in) begin
                r_rdy  <= 1'b1;
                r_inst <= w_fill_word;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cache2if_rdy     = r_rdy;
  assign cache2if_inst    = r_inst;
  assign cache2mem_upd_en = r_upd_en;
  assign cache2mem_PC     = r_mem_pc;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed table-driven bench for icache
module tb_icache;

  logic         clk = 1'b0;
  logic         rst_in, rdy_in, flush_in;
  logic         if2cache_en;
  logic [31:0]  if2cache_pc;
  logic         cache2if_rdy;
  logic [31:0]  cache2if_inst;
  logic         cache2mem_upd_en;
  logic [31:0]  cache2mem_PC;
  logic         mem2cache_upd;
  logic [127:0] mem2cache_blk;
  logic [3:0]   mem2cache_idx;
  logic [23:0]  mem2cache_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if2cache_en(if2cache_en), .if2cache_pc(if2cache_pc),
    .cache2if_rdy(cache2if_rdy), .cache2if_inst(cache2if_inst),
    .cache2mem_upd_en(cache2mem_upd_en), .cache2mem_PC(cache2mem_PC),
    .mem2cache_upd(mem2cache_upd), .mem2cache_blk(mem2cache_blk),
    .mem2cache_idx(mem2cache_idx), .mem2cache_tag(mem2cache_tag)
  );

  typedef struct {
    logic [31:0]  pc;
    logic         hit;
    logic [31:0]  inst;
    logic [127:0] blk;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] pc);
    if2cache_en = 1'b1;
    if2cache_pc = pc;
    step();
    if2cache_en = 1'b0;
  endtask

  task automatic fill(input logic [31:0] pc, input logic [127:0] blk);
    mem2cache_upd = 1'b1;
    mem2cache_blk = blk;
    mem2cache_idx = pc[7:4];
    mem2cache_tag = pc[31:8];
    step();
    mem2cache_upd = 1'b0;
  endtask

  logic [127:0] blk_a, blk_b, blk_c, blk_d, blk_e, blk_n, blk_f;
  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    blk_a = {32'h00C00113, 32'h00800113, 32'h00500093, 32'h00000013};
    blk_b = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
    blk_c = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    blk_d = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    blk_e = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
    blk_n = {32'h93939393, 32'h92929292, 32'h91919191, 32'h90909090};
    blk_f = {32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1, 32'hF0F0F0F0};

    vecs[0] = '{32'h0000010C, 1'b1, 32'h00C00113, 128'h0};
    vecs[1] = '{32'h00000100, 1'b1, 32'h00000013, 128'h0};
    vecs[2] = '{32'h00000130, 1'b0, 32'hB0B0B0B0, blk_b};
    vecs[3] = '{32'h0000013E, 1'b1, 32'hB3B3B3B3, 128'h0};
    vecs[4] = '{32'h00000134, 1'b1, 32'hB1B1B1B1, 128'h0};
    vecs[5] = '{32'h00001104, 1'b0, 32'hC1C1C1C1, blk_c};
    vecs[6] = '{32'h00001108, 1'b1, 32'hC2C2C2C2, 128'h0};
    vecs[7] = '{32'h00000104, 1'b0, 32'h00500093, blk_a};
    vecs[8] = '{32'h00000138, 1'b1, 32'hB2B2B2B2, 128'h0};

    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    if2cache_en = 1'b0; if2cache_pc = '0;
    mem2cache_upd = 1'b0; mem2cache_blk = '0; mem2cache_idx = '0; mem2cache_tag = '0;
    step(); step();
    rst_in = 1'b0;
    check("reset_rdy", {31'b0, cache2if_rdy}, 32'd0);
    check("reset_inst", cache2if_inst, 32'd0);
    check("reset_upd_en", {31'b0, cache2mem_upd_en}, 32'd0);
    check("reset_mem_pc", cache2mem_PC, 32'd0);

    // Cold miss on 0x104
    req(32'h00000104);
    check("cold_upd_en", {31'b0, cache2mem_upd_en}, 32'd1);
    check("cold_mem_pc", cache2mem_PC, 32'h00000100);
    check("cold_no_rdy", {31'b0, cache2if_rdy}, 32'd0);
    step(); step();
    check("cold_upd_hold", {31'b0, cache2mem_upd_en}, 32'd1);
    check("cold_pc_stable", cache2mem_PC, 32'h00000100);
    fill(32'h00000100, blk_a);
    check("cold_rdy", {31'b0, cache2if_rdy}, 32'd1);
    check("cold_inst", cache2if_inst, 32'h00500093);
    check("cold_upd_drop", {31'b0, cache2mem_upd_en}, 32'd0);
    step();
    check("cold_rdy_pulse", {31'b0, cache2if_rdy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      req(vecs[i].pc);
      if (vecs[i].hit) begin
        check($sformatf("v%0d_hit_rdy", i), {31'b0, cache2if_rdy}, 32'd1);
        check($sformatf("v%0d_hit_inst", i), cache2if_inst, vecs[i].inst);
        check($sformatf("v%0d_hit_nomem", i), {31'b0, cache2mem_upd_en}, 32'd0);
      end else begin
        check($sformatf("v%0d_miss_rdy", i), {31'b0, cache2if_rdy}, 32'd0);
        check($sformatf("v%0d_miss_upd", i), {31'b0, cache2mem_upd_en}, 32'd1);
        check($sformatf("v%0d_miss_pc", i), cache2mem_PC, {vecs[i].pc[31:4], 4'b0});
        step();
        fill({vecs[i].pc[31:4], 4'b0}, vecs[i].blk);
        check($sformatf("v%0d_fill_rdy", i), {31'b0, cache2if_rdy}, 32'd1);
        check($sformatf("v%0d_fill_inst", i), cache2if_inst, vecs[i].inst);
        check($sformatf("v%0d_fill_upd", i), {31'b0, cache2mem_upd_en}, 32'd0);
      end
      step();
      check($sformatf("v%0d_pulse_end", i), {31'b0, cache2if_rdy}, 32'd0);
    end

    // Back-to-back hits
    if2cache_en = 1'b1; if2cache_pc = 32'h00000100;
    step();
    check("b2b_rdy0", {31'b0, cache2if_rdy}, 32'd1);
    check("b2b_inst0", cache2if_inst, 32'h00000013);
    if2cache_pc = 32'h00000108;
    step();
    if2cache_en = 1'b0;
    check("b2b_rdy1", {31'b0, cache2if_rdy}, 32'd1);
    check("b2b_inst1", cache2if_inst, 32'h00800113);
    step();

    // Non-matching fill keeps waiting but still writes its line
    req(32'h00000254);
    fill(32'h00000970, blk_n);
    check("nm_no_rdy", {31'b0, cache2if_rdy}, 32'd0);
    check("nm_upd_hold", {31'b0, cache2mem_upd_en}, 32'd1);
    check("nm_pc_stable", cache2mem_PC, 32'h00000250);
    fill(32'h00000250, blk_e);
    check("nm_rdy", {31'b0, cache2if_rdy}, 32'd1);
    check("nm_inst", cache2if_inst, 32'hE1E1E1E1);
    step();
    req(32'h0000097C);
    check("nm_line_hit", {31'b0, cache2if_rdy}, 32'd1);
    check("nm_line_inst", cache2if_inst, 32'h93939393);
    step();

    // Flush during miss: request at t, flush at t+3, fill at t+10
    req(32'h00000200);
    step();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("fl_upd_wait", {31'b0, cache2mem_upd_en}, 32'd1);
    fill(32'h00000200, blk_d);
    check("fl_no_rdy", {31'b0, cache2if_rdy}, 32'd0);
    check("fl_upd_drop", {31'b0, cache2mem_upd_en}, 32'd0);
    step();
    check("fl_no_rdy_late", {31'b0, cache2if_rdy}, 32'd0);
    req(32'h00000200);
    check("fl_hit_rdy", {31'b0, cache2if_rdy}, 32'd1);
    check("fl_hit_inst", cache2if_inst, 32'hD0D0D0D0);
    step();

    // Flush in IDLE suppresses a request
    flush_in = 1'b1;
    req(32'h00000200);
    flush_in = 1'b0;
    check("fli_no_rdy", {31'b0, cache2if_rdy}, 32'd0);
    check("fli_no_mem", {31'b0, cache2mem_upd_en}, 32'd0);

    // Flush coincident with fill
    req(32'h00000308);
    flush_in = 1'b1;
    fill(32'h00000300, blk_f);
    flush_in = 1'b0;
    check("flf_no_rdy", {31'b0, cache2if_rdy}, 32'd0);
    check("flf_upd_drop", {31'b0, cache2mem_upd_en}, 32'd0);
    req(32'h00000308);
    check("flf_hit_rdy", {31'b0, cache2if_rdy}, 32'd1);
    check("flf_hit_inst", cache2if_inst, 32'hF2F2F2F2);
    step();

    // Stall holds the response pulse
    req(32'h0000013C);
    rdy_in = 1'b0;
    check("st_rdy_t1", {31'b0, cache2if_rdy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("st_hold%0d", k), {31'b0, cache2if_rdy}, 32'd1);
      check($sformatf("st_inst%0d", k), cache2if_inst, 32'hB3B3B3B3);
    end
    rdy_in = 1'b1;
    step();
    check("st_release", {31'b0, cache2if_rdy}, 32'd0);
    step();
    check("st_single", {31'b0, cache2if_rdy}, 32'd0);

    // Reset mid-miss with a coincident fill
    req(32'h00000400);
    check("rm_upd", {31'b0, cache2mem_upd_en}, 32'd1);
    rst_in = 1'b1;
    fill(32'h00000400, blk_d);
    rst_in = 1'b0;
    check("rm_upd_drop", {31'b0, cache2mem_upd_en}, 32'd0);
    check("rm_no_rdy", {31'b0, cache2if_rdy}, 32'd0);
    check("rm_mem_pc", cache2mem_PC, 32'd0);
    step();
    check("rm_no_rdy_late", {31'b0, cache2if_rdy}, 32'd0);
    req(32'h00000130);
    check("rm_refetch_miss", {31'b0, cache2mem_upd_en}, 32'd1);
    check("rm_refetch_nordy", {31'b0, cache2if_rdy}, 32'd0);
    step();
    fill(32'h00000130, blk_b);
    check("rm_refill_inst", cache2if_inst, 32'hB0B0B0B0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
